store_narrow: RTL
=================

Name: store_narrow

Overview:
- Store-path narrowing unit between the CPU's 32-bit memory stage and an 8-bit byte-wide data memory port.
- Accepts one sw/sh/sb request per transaction and serializes it into 4/2/1 byte writes, little-endian.
- Checks alignment and raises an error pulse on a bad request instead of writing.
- This is the narrowing counterpart of the immediate/load widening logic: 32-bit in, truncated byte lanes out.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_op  input  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
- req_addr  input  ADDR_W  byte address of the store.
- req_data  input  32  store data, taken from rt.
- mem_we  output  1  byte write strobe.
- mem_ready  input  1  memory accepts the current byte this cycle.
- mem_addr  output  ADDR_W  byte address being written.
- mem_wdata  output  8  byte being written.
- done  output  1  one-cycle pulse: request completed successfully.
- err  output  1  one-cycle pulse: request rejected (misaligned or reserved op).

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0. State is IDLE and the byte counter is 0.
- States:
  - IDLE: req_ready=1.
  - SEND: req_ready=0, mem_we=1.
- Accept: a request is accepted on the rising edge where req_valid && req_ready. The unit latches op, addr and data, then checks the request:
  - Legal: sw with addr[1:0]==00; sh with addr[0]==0; sb at any address.
  - Illegal (misaligned or op 11): state stays IDLE, err=1 for exactly the next cycle, no mem_we ever asserted, done=0.
  - Legal: next cycle state=SEND, counter i=0, mem_addr=addr, mem_wdata=data[7:0].
- Byte count N: sw = 4, sh = 2, sb = 1. For sh and sb only the low bytes of req_data are used; upper bits are discarded, with no overflow check.
- SEND, each cycle:
  - mem_we && mem_ready ends byte i.
  - If i < N-1: next cycle i=i+1, mem_addr=addr+i+1, mem_wdata=data[8(i+1)+7 : 8(i+1)].
  - If i == N-1: next cycle state=IDLE, mem_we=0, done=1 for one cycle, req_ready=1.
  - mem_ready=0: hold mem_we, mem_addr and mem_wdata stable. There is no timeout.
- Latency: an sb with mem_ready tied high takes accept at cycle T, write at T+1, done at T+2. sw with no stalls gives done at T+5.
- Back-to-back: in the cycle done=1, req_ready=1 and a new request may be accepted. Its first byte appears the following cycle, so there is no bubble beyond done.
- req_* inputs are ignored while req_ready=0. req_data and req_addr need not be held after accept.
- mem_addr arithmetic wraps modulo 2^ADDR_W.
- Reset in any state, including mid-SEND or while mem_ready=0: the next cycle shows the reset values. The partial store is abandoned and neither done nor err is raised.
- done and err are never both 1 in the same cycle.

Test Plan:
- sw addr=0x100, data=0xA1B2C3D4, mem_ready=1 -> writes (0x100,D4), (0x101,C3), (0x102,B2), (0x103,A1) on 4 consecutive cycles, then done pulse; req_ready=0 throughout SEND.
- sh addr=0x202, data=0xFFFF1234 -> writes (0x202,34), (0x203,12), done; upper half not written. sb addr=0x7 data=0x000000EE -> single write (0x7,EE), done at T+2.
- Misaligned: sw addr=0x102, sh addr=0x9, op=11 addr=0 -> each gives err=1 one cycle after accept; mem_we stays 0; done stays 0.
- Backpressure: sw addr=0x40 data=0x11223344, mem_ready low 3 cycles on byte 1 -> mem_addr=0x41 and mem_wdata=0x33 held stable; bytes complete in order; done after byte 3.
- Reset mid-op: sw accepted, reset asserted during byte 2 -> next cycle mem_we=0, req_ready=1, no done. A new sb addr=0x5 data=0x77 then completes normally.
- Back-to-back: sb then sh presented with req_valid held high -> second request accepted in the done cycle of the first; its first write follows on the next cycle.

Source files
------------

// File: rtl/store_narrow.sv
// -----------------------------------------------------------------------------
// store_narrow
//
// Store-path narrowing unit. Takes one 32-bit store request (sw/sh/sb) from
// the memory stage and serialises it into 4/2/1 little-endian byte writes on
// a byte-wide memory port. Misaligned requests and the reserved opcode are
// rejected with a one-cycle err pulse and never reach memory.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   req_valid  store request present
//   req_ready  unit can accept a request this cycle (registered)
//   req_op     00 = sw, 01 = sh, 10 = sb, 11 = reserved
//   req_addr   byte address of the store
//   req_data   store data (rt)
//   mem_we     byte write strobe (registered)
//   mem_ready  memory accepts the current byte this cycle
//   mem_addr   byte address being written (registered)
//   mem_wdata  byte being written (registered)
//   done       one-cycle pulse: request completed
//   err        one-cycle pulse: request rejected
// -----------------------------------------------------------------------------
module store_narrow #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] OP_SW = 2'b00;
    localparam logic [1:0] OP_SH = 2'b01;
    localparam logic [1:0] OP_SB = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_reg,     state_next;
    logic [1:0]        cnt_reg,       cnt_next;
    logic [1:0]        last_reg,      last_next;
    logic [31:0]       data_reg,      data_next;
    logic              req_ready_reg, req_ready_next;
    logic              mem_we_reg,    mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic              done_reg,      done_next;
    logic              err_reg,       err_next;

    // Byte lanes of the latched store data, little-endian.
    logic [7:0] data_bytes [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign data_bytes[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

    logic       req_legal;
    logic [1:0] req_last;
    logic [1:0] cnt_inc;

    always_comb begin
        req_legal = 1'b0;
        req_last  = 2'd0;
        unique case (req_op)
            OP_SW: begin
                req_legal = (req_addr[1:0] == 2'b00);
                req_last  = 2'd3;
            end
            OP_SH: begin
                req_legal = (req_addr[0] == 1'b0);
                req_last  = 2'd1;
            end
            OP_SB: begin
                req_legal = 1'b1;
                req_last  = 2'd0;
            end
            default: begin
                req_legal = 1'b0;
                req_last  = 2'd0;
            end
        endcase
    end

    assign cnt_inc = cnt_reg + 2'd1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        data_next      = data_reg;
        req_ready_next = req_ready_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (req_valid && req_ready_reg) begin
                    if (req_legal) begin
                        // First byte goes out straight from the request so
                        // that there is no bubble after accept.
                        state_next     = SEND;
                        cnt_next       = 2'd0;
                        last_next      = req_last;
                        data_next      = req_data;
                        req_ready_next = 1'b0;
                        mem_we_next    = 1'b1;
                        mem_addr_next  = req_addr;
                        mem_wdata_next = req_data[7:0];
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SEND: begin
                // mem_we is always high in SEND; mem_ready alone ends a byte.
                // With mem_ready low every output register simply holds.
                if (mem_ready) begin
                    if (cnt_reg == last_reg) begin
                        state_next     = IDLE;
                        mem_we_next    = 1'b0;
                        req_ready_next = 1'b1;
                        done_next      = 1'b1;
                    end else begin
                        cnt_next       = cnt_inc;
                        // Incrementing the previous address equals addr+i+1
                        // and wraps naturally at the address width.
                        mem_addr_next  = mem_addr_reg + ADDR_W'(1);
                        mem_wdata_next = data_bytes[cnt_inc];
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 2'd0;
            last_reg      <= 2'd0;
            data_reg      <= 32'd0;
            req_ready_reg <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= 8'd0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            data_reg      <= data_next;
            req_ready_reg <= req_ready_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
